// File: rtl/melody_recorder.sv
// Collects key presses from the key-press counter stage into a melody of NOTES {key,dur} slots.
// The finished melody is offered to the population stage over a valid/ready handshake.
module melody_recorder #(
  parameter int unsigned NOTES         = 8,
  parameter int unsigned TIMEOUT_TICKS = 120
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 trigger,
  input  logic [3:0]           counter_in,
  input  logic [2:0]           key_played_in,
  input  logic [2:0]           note_duration_in,
  input  logic                 keys_held_in,
  input  logic                 flush_in,
  output logic [NOTES*6-1:0]   melody_out,
  output logic [3:0]           note_count_out,
  output logic                 melody_valid,
  input  logic                 melody_ready,
  output logic                 drop_out
);

  localparam int unsigned IW = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_FULL    = 2'd2;

  logic [1:0]         state, state_d;
  logic [3:0]         counter_q;
  logic [2:0]         pend_key, pend_dur;
  logic               pend_v;
  logic [IW-1:0]      idle_ticks;
  logic [NOTES*6-1:0] melody;
  logic [3:0]         note_count;
  logic               drop;

  logic new_press, timeout, handshake, commit;

  assign new_press = (counter_in != counter_q) && (counter_in != 4'd0);
  assign timeout   = trigger && (idle_ticks == IW'(TIMEOUT_TICKS - 1)) && !keys_held_in;
  assign handshake = (state == S_FULL) && melody_ready;

  always_comb begin
    commit  = 1'b0;
    state_d = state;
    case (state)
      S_IDLE: begin
        if (flush_in && note_count != 4'd0) state_d = S_FULL;
        else if (new_press)                 state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (new_press) begin
          commit  = 1'b1;
          state_d = flush_in ? S_FULL : S_CAPTURE;
        end else if (flush_in) begin
          commit  = 1'b1;
          state_d = S_FULL;
        end else if (timeout) begin
          commit  = 1'b1;
          state_d = S_IDLE;
        end
        if (commit && note_count == 4'(NOTES - 1)) state_d = S_FULL;
      end
      S_FULL: begin
        // A press arriving alongside the handshake must still be captured.
        if (handshake) state_d = (pend_v || new_press) ? S_CAPTURE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state      <= S_IDLE;
      counter_q  <= '0;
      pend_key   <= '0;
      pend_dur   <= '0;
      pend_v     <= 1'b0;
      idle_ticks <= '0;
      melody     <= '0;
      note_count <= '0;
      drop       <= 1'b0;
    end else begin
      counter_q <= counter_in;
      state     <= state_d;
      drop      <= (state == S_FULL) && new_press && pend_v;

      // Duration tracks upstream one cycle late so the final value survives the next press.
      if (new_press) begin
        pend_key <= key_played_in;
        pend_dur <= '0;
        pend_v   <= 1'b1;
      end else begin
        if (pend_v) pend_dur <= note_duration_in;
        if (commit) pend_v   <= 1'b0;
      end

      if (new_press || keys_held_in)             idle_ticks <= '0;
      else if (trigger && state == S_CAPTURE)    idle_ticks <= idle_ticks + 1'b1;

      if (handshake) begin
        melody     <= '0;
        note_count <= '0;
      end else if (commit) begin
        for (int unsigned i = 0; i < NOTES; i++) begin
          if (note_count == 4'(i)) melody[i*6 +: 6] <= {pend_key, pend_dur};
        end
        note_count <= note_count + 4'd1;
      end
    end
  end

  assign melody_out     = melody;
  assign note_count_out = note_count;
  assign melody_valid   = (state == S_FULL);
  assign drop_out       = drop;

endmodule

// File: tb/tb_melody_recorder.sv
// Scoreboard bench for melody_recorder: a small upstream model drives presses, completed
// melodies are queued as expected and compared when the handshake takes them.
module tb_melody_recorder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        trigger;
  logic [3:0]  counter_in;
  logic [2:0]  key_played_in;
  logic [2:0]  note_duration_in;
  logic        keys_held_in;
  logic        flush_in;
  logic [47:0] melody_out;
  logic [3:0]  note_count_out;
  logic        melody_valid;
  logic        melody_ready;
  logic        drop_out;

  melody_recorder #(.NOTES(8), .TIMEOUT_TICKS(120)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .trigger          (trigger),
    .counter_in       (counter_in),
    .key_played_in    (key_played_in),
    .note_duration_in (note_duration_in),
    .keys_held_in     (keys_held_in),
    .flush_in         (flush_in),
    .melody_out       (melody_out),
    .note_count_out   (note_count_out),
    .melody_valid     (melody_valid),
    .melody_ready     (melody_ready),
    .drop_out         (drop_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [47:0] mel;
    int unsigned cnt;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned drop_cnt = 0;
  logic [47:0] mdl;
  int unsigned mcnt;
  logic [3:0]  up_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic model_add(input logic [2:0] k, input logic [2:0] d);
    mdl[mcnt*6 +: 6] = {k, d};
    mcnt++;
  endtask

  task automatic push_expected();
    exp_t e;
    e.mel = mdl;
    e.cnt = mcnt;
    sb.push_back(e);
    mdl  = '0;
    mcnt = 0;
  endtask

  task automatic press(input logic [2:0] k);
    up_cnt           = (up_cnt == 4'd8) ? 4'd1 : up_cnt + 4'd1;
    counter_in       = up_cnt;
    key_played_in    = k;
    note_duration_in = '0;
    keys_held_in     = 1'b1;
    tick();
  endtask

  task automatic hold_release(input logic [2:0] d);
    note_duration_in = d;
    tick();
    tick();
    keys_held_in = 1'b0;
    tick();
  endtask

  task automatic flush_pulse();
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
  endtask

  task automatic handshake();
    melody_ready = 1'b1;
    tick();
    melody_ready = 1'b0;
    check("hs_valid_drop", melody_valid, 0);
    check("hs_count_clr", note_count_out, 0);
  endtask

  always @(negedge clk_in) begin
    if (rst_in === 1'b1 && drop_out === 1'b1) drop_cnt++;
    if (rst_in === 1'b1 && melody_valid === 1'b1 && melody_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_unexpected", sb.size(), 1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_melody", melody_out, e.mel);
        check("sb_count", note_count_out, e.cnt);
      end
    end
  end

  initial begin
    logic [2:0]  durs [8];
    logic [2:0]  k, d, k2;
    logic [47:0] snap;
    int unsigned changes, d0;

    durs = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7};
    mdl  = '0;
    mcnt = 0;

    // Reset with random inputs
    rst_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      trigger          = 1'($urandom_range(1));
      counter_in       = 4'($urandom_range(15));
      key_played_in    = 3'($urandom_range(7));
      note_duration_in = 3'($urandom_range(7));
      keys_held_in     = 1'($urandom_range(1));
      flush_in         = 1'($urandom_range(1));
      melody_ready     = 1'($urandom_range(1));
      tick();
    end
    check("rst_melody", melody_out, 0);
    check("rst_count", note_count_out, 0);
    check("rst_valid", melody_valid, 0);
    check("rst_drop", drop_out, 0);
    trigger = 0; counter_in = 0; key_played_in = 0; note_duration_in = 0;
    keys_held_in = 0; flush_in = 0; melody_ready = 0;
    up_cnt = 4'd0;
    rst_in = 1'b1;
    repeat (3) tick();
    check("idle_valid", melody_valid, 0);
    check("idle_count", note_count_out, 0);

    // A zero counter after reset must not have produced a phantom note
    press(3'd2);
    hold_release(3'd3);
    model_add(3'd2, 3'd3);
    push_expected();
    flush_pulse();
    check("no_phantom_count", note_count_out, 1);
    check("no_phantom_valid", melody_valid, 1);
    handshake();

    // Eight notes plus a ninth press
    for (int i = 0; i < 8; i++) begin
      press(3'(i));
      hold_release(durs[i]);
      model_add(3'(i), durs[i]);
    end
    press(3'd3);
    check("eight_valid", melody_valid, 1);
    check("eight_count", note_count_out, 8);
    check("eight_melody", melody_out, mdl);
    push_expected();
    handshake();
    hold_release(3'd4);
    model_add(3'd3, 3'd4);
    push_expected();
    flush_pulse();
    check("ninth_count", note_count_out, 1);
    check("ninth_slot0", melody_out[5:0], 6'b011100);
    handshake();

    // Backpressure
    for (int i = 0; i < 8; i++) begin
      k = 3'($urandom_range(7));
      d = 3'($urandom_range(1, 7));
      press(k);
      hold_release(d);
      model_add(k, d);
    end
    push_expected();
    flush_pulse();
    check("bp_valid", melody_valid, 1);
    check("bp_count", note_count_out, 8);
    snap    = melody_out;
    changes = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (melody_out !== snap) changes++;
    end
    check("bp_stable", changes, 0);
    d0 = drop_cnt;
    press(3'd6);
    hold_release(3'd2);
    k2 = 3'($urandom_range(7));
    press(k2);
    hold_release(3'd5);
    check("bp_drop_once", drop_cnt - d0, 1);
    check("bp_frozen", melody_out, snap);
    check("bp_count_frozen", note_count_out, 8);
    handshake();
    model_add(k2, 3'd5);
    push_expected();
    flush_pulse();
    check("bp_pending_count", note_count_out, 1);
    handshake();

    // Release timeout
    press(3'd5);
    note_duration_in = 3'd1;
    tick();
    note_duration_in = 3'd2;
    tick();
    keys_held_in = 1'b0;
    tick();
    for (int i = 0; i < 119; i++) begin
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      tick();
    end
    check("to_119_count", note_count_out, 0);
    check("to_119_melody", melody_out, 0);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    check("to_count", note_count_out, 1);
    check("to_slot0", melody_out[5:0], 6'b101010);
    check("to_valid", melody_valid, 0);
    model_add(3'd5, 3'd2);
    push_expected();
    flush_pulse();
    check("idle_flush_valid", melody_valid, 1);
    handshake();

    // Early flush after three notes
    for (int i = 0; i < 3; i++) begin
      k = 3'($urandom_range(7));
      d = 3'($urandom_range(1, 7));
      press(k);
      hold_release(d);
      model_add(k, d);
    end
    push_expected();
    flush_pulse();
    check("fl_valid", melody_valid, 1);
    check("fl_count", note_count_out, 3);
    check("fl_upper_zero", melody_out[47:18], 0);
    handshake();

    // Press and flush in the same cycle
    press(3'd1);
    hold_release(3'd6);
    model_add(3'd1, 3'd6);
    push_expected();
    up_cnt           = (up_cnt == 4'd8) ? 4'd1 : up_cnt + 4'd1;
    counter_in       = up_cnt;
    key_played_in    = 3'd7;
    note_duration_in = '0;
    keys_held_in     = 1'b1;
    flush_in         = 1'b1;
    tick();
    flush_in     = 1'b0;
    keys_held_in = 1'b0;
    check("pf_valid", melody_valid, 1);
    check("pf_count", note_count_out, 1);
    handshake();

    // Reset while a melody is waiting
    flush_pulse();
    check("rf_valid_before", melody_valid, 1);
    rst_in = 1'b0;
    tick();
    check("rf_valid", melody_valid, 0);
    check("rf_melody", melody_out, 0);
    check("rf_count", note_count_out, 0);
    rst_in     = 1'b1;
    counter_in = 4'd0;
    tick();
    check("rf_valid_after", melody_valid, 0);

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
